vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator for the VGA_Control path. It sits directly downstream of the resolution configuration stage and latches the per-resolution timing parameters whenever `Load_config` pulses. It runs horizontal and vertical counters against those parameters and produces registered sync, active-video and frame/line strobes for the pixel-output stage.

## Interface
Parameters:
- PULSE_WIDTH, 8, width of sync pulse lengths
- REZ_MAX_WIDTH, 11, width of total-count values and internal counters
- HL_MARGIN_WIDTH, 8, width of horizontal back porch
- HR_MARGIN_WIDTH, 8, width of horizontal front porch
- VL_MARGIN_WIDTH, 6, width of vertical back porch
- VR_MARGIN_WIDTH, 4, width of vertical front porch

Ports:
- Clk  in  1  pixel clock
- Rst  in  1  reset, asynchronous, active-low
- Load_config  in  1  single-cycle strobe: latch new parameters and restart raster
- H_sync_pulse / V_sync_pulse  in  PULSE_WIDTH  sync pulse length, in pixels / lines
- H_count_max / V_count_max  in  REZ_MAX_WIDTH  last counter value of a line / frame (total − 1)
- H_left_margin / V_left_margin  in  HL_/VL_MARGIN_WIDTH  back porch length
- H_right_margin / V_right_margin  in  HR_/VR_MARGIN_WIDTH  front porch length
- H_sync  out  1  high during horizontal sync pulse
- V_sync  out  1  high during vertical sync pulse
- Active  out  1  high on visible pixels
- Line_end  out  1  one-cycle strobe on the last pixel of each line
- Frame_start  out  1  one-cycle strobe on pixel (0,0) of each frame
- X  out  REZ_MAX_WIDTH  visible pixel column (only with PIX_COORD_EN)
- Y  out  REZ_MAX_WIDTH  visible pixel row (only with PIX_COORD_EN)

## Operation
- FSM states:
  - WAIT_LOAD: entered on reset. All outputs are 0 and counters are held at 0.
  - RUN: entered on `Load_config`.
- `Load_config`=1 in any state:
  - Copy all eight inputs into shadow registers.
  - Clear h_cnt and v_cnt to 0.
  - Go to RUN.
  - Inputs are ignored outside `Load_config` cycles; upstream may change them freely.
- `Load_config` held high for N cycles: counters stay at 0 and shadows re-latch every cycle. Counting starts on the first cycle after it falls.
- RUN, per cycle:
  - If h_cnt==H_count_max: h_cnt←0, and v_cnt←(v_cnt==V_count_max)?0:v_cnt+1.
  - Otherwise h_cnt←h_cnt+1.
- Horizontal segment order:
  - sync: [0, Hp−1]
  - back porch: [Hp, Hp+Hl−1]
  - active: [Hp+Hl, Hmax−Hr]
  - front porch: [Hmax−Hr+1, Hmax]
- Vertical segments use the same order with the V parameters, evaluated on v_cnt.
- Active = h_active AND v_active.
- Line_end = (h_cnt==Hmax). Frame_start = (h_cnt==0 && v_cnt==0).
- Comparisons are unsigned at REZ_MAX_WIDTH; margin and pulse inputs are zero-extended.
- If Hp+Hl > Hmax−Hr, Active is never asserted; counters and syncs still run. Same rule applies vertically.
- Hp=0: H_sync is never asserted. V_sync is treated the same way.

## Timing
- All outputs are registered and decoded from counter values, so each output lags its counter state by 1 cycle.
- First Frame_start appears 2 cycles after the `Load_config` cycle. That is 1 cycle for counters to start at 0, plus 1 output register.
- `Load_config` mid-frame aborts the frame. Next cycle all outputs are 0; the new raster then follows the rule above.
- Reset: all outputs 0 immediately (asynchronous); state goes to WAIT_LOAD; shadow registers cleared to 0.
- Wrap-around: the last pixel of the frame (Hmax,Vmax) gives Line_end=1. The next cycle gives Frame_start=1 with no gap.

## Configuration
- `PIX_COORD_EN` defined:
  - X = h_cnt−(Hp+Hl) and Y = v_cnt−(Vp+Vl), registered alongside Active.
  - X and Y are 0 whenever Active=0.
- `PIX_COORD_EN` undefined: X/Y logic is removed and both ports are tied to 0.

## Test plan
- 640x480 (Hmax 799, Hp 96, Hl 48, Hr 16; Vmax 524, Vp 2, Vl 33, Vr 10) -> exactly 640 Active cycles per visible line, at h 144..783. Active covers 480 lines, at v 35..514. Frame_start every 420000 cycles.
- Same config -> H_sync high for 96 cycles per line. V_sync high for 2×800 cycles per frame.
- Reset asserted mid-line -> all outputs 0 asynchronously. No output activity until `Load_config`; first Frame_start 2 cycles after it.
- Load 800x600 (Hmax 1055, Hp 128, Hl 88, Hr 40; Vmax 627, Vp 4, Vl 23, Vr 1) at v=200 of a 640x480 frame -> next cycle outputs are 0. Afterwards 800 Active pixels per line at h 216..1015.
- Degenerate config Hmax 9, Hp 4, Hl 4, Hr 4 -> Active never asserted; Line_end every 10 cycles.
- With `PIX_COORD_EN`, 640x480 -> X runs 0..639 and Y 0..479 on Active cycles, and both are 0 elsewhere.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: h/v counters, sync, active and frame/line strobes
//
// Purpose:
//   Latches per-resolution timing parameters on Load_config, runs horizontal
//   and vertical counters against them and produces registered sync,
//   active-video and line/frame strobes for the pixel-output stage.
//
// Optional feature macro: PIX_COORD_EN
//   defined   -> X/Y carry the visible pixel column/row (0 outside Active)
//   undefined -> X/Y are tied to 0
//
// Ports:
//   Clk            pixel clock
//   Rst            asynchronous active-low reset
//   Load_config    strobe: latch parameters, restart raster
//   H_/V_sync_pulse, H_/V_count_max, H_/V_left_margin, H_/V_right_margin
//                  timing parameters, sampled only while Load_config is high
//   H_sync, V_sync sync pulses
//   Active         visible pixel
//   Line_end       last pixel of every line
//   Frame_start    pixel (0,0) of every frame
//   X, Y           visible pixel coordinates

module vga_timing_gen #(
    parameter int PULSE_WIDTH     = 8,
    parameter int REZ_MAX_WIDTH   = 11,
    parameter int HL_MARGIN_WIDTH = 8,
    parameter int HR_MARGIN_WIDTH = 8,
    parameter int VL_MARGIN_WIDTH = 6,
    parameter int VR_MARGIN_WIDTH = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Load_config,
    input  logic [PULSE_WIDTH-1:0]     H_sync_pulse,
    input  logic [PULSE_WIDTH-1:0]     V_sync_pulse,
    input  logic [REZ_MAX_WIDTH-1:0]   H_count_max,
    input  logic [REZ_MAX_WIDTH-1:0]   V_count_max,
    input  logic [HL_MARGIN_WIDTH-1:0] H_left_margin,
    input  logic [VL_MARGIN_WIDTH-1:0] V_left_margin,
    input  logic [HR_MARGIN_WIDTH-1:0] H_right_margin,
    input  logic [VR_MARGIN_WIDTH-1:0] V_right_margin,
    output logic                       H_sync,
    output logic                       V_sync,
    output logic                       Active,
    output logic                       Line_end,
    output logic                       Frame_start,
    output logic [REZ_MAX_WIDTH-1:0]   X,
    output logic [REZ_MAX_WIDTH-1:0]   Y
);

    localparam int W = REZ_MAX_WIDTH;

    typedef enum logic {
        WAIT_LOAD = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t state;

    logic [W-1:0] h_cnt;
    logic [W-1:0] v_cnt;

    // Shadow copies of the timing parameters
    logic [PULSE_WIDTH-1:0]     h_pulse;
    logic [PULSE_WIDTH-1:0]     v_pulse;
    logic [W-1:0]               h_max;
    logic [W-1:0]               v_max;
    logic [HL_MARGIN_WIDTH-1:0] h_left;
    logic [VL_MARGIN_WIDTH-1:0] v_left;
    logic [HR_MARGIN_WIDTH-1:0] h_right;
    logic [VR_MARGIN_WIDTH-1:0] v_right;

    // Active window bounds, all arithmetic wraps at W bits
    logic [W-1:0] h_act_start;
    logic [W-1:0] h_act_end;
    logic [W-1:0] v_act_start;
    logic [W-1:0] v_act_end;

    logic h_sync_d;
    logic v_sync_d;
    logic h_act_d;
    logic v_act_d;
    logic active_d;
    logic line_end_d;
    logic frame_start_d;

    assign h_act_start = W'(h_pulse) + W'(h_left);
    assign h_act_end   = h_max - W'(h_right);
    assign v_act_start = W'(v_pulse) + W'(v_left);
    assign v_act_end   = v_max - W'(v_right);

    // A zero pulse length makes the "< pulse" test never true, so Hp=0 / Vp=0
    // naturally suppress the sync output.
    assign h_sync_d = (h_cnt < W'(h_pulse));
    assign v_sync_d = (v_cnt < W'(v_pulse));

    // When the start bound exceeds the end bound the window is empty, which
    // covers the degenerate-porch case without a separate check.
    assign h_act_d  = (h_cnt >= h_act_start) && (h_cnt <= h_act_end);
    assign v_act_d  = (v_cnt >= v_act_start) && (v_cnt <= v_act_end);
    assign active_d = h_act_d && v_act_d;

    assign line_end_d    = (h_cnt == h_max);
    assign frame_start_d = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= WAIT_LOAD;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_pulse     <= '0;
            v_pulse     <= '0;
            h_max       <= '0;
            v_max       <= '0;
            h_left      <= '0;
            v_left      <= '0;
            h_right     <= '0;
            v_right     <= '0;
            H_sync      <= 1'b0;
            V_sync      <= 1'b0;
            Active      <= 1'b0;
            Line_end    <= 1'b0;
            Frame_start <= 1'b0;
`ifdef PIX_COORD_EN
            X           <= '0;
            Y           <= '0;
`endif
        end else if (Load_config) begin
            // Restart: outputs go quiet for this cycle, counting resumes
            // from (0,0) once the strobe drops.
            state       <= RUN;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_pulse     <= H_sync_pulse;
            v_pulse     <= V_sync_pulse;
            h_max       <= H_count_max;
            v_max       <= V_count_max;
            h_left      <= H_left_margin;
            v_left      <= V_left_margin;
            h_right     <= H_right_margin;
            v_right     <= V_right_margin;
            H_sync      <= 1'b0;
            V_sync      <= 1'b0;
            Active      <= 1'b0;
            Line_end    <= 1'b0;
            Frame_start <= 1'b0;
`ifdef PIX_COORD_EN
            X           <= '0;
            Y           <= '0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (h_cnt == h_max) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == v_max) ? '0 : v_cnt + 1'b1;
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                    H_sync      <= h_sync_d;
                    V_sync      <= v_sync_d;
                    Active      <= active_d;
                    Line_end    <= line_end_d;
                    Frame_start <= frame_start_d;
`ifdef PIX_COORD_EN
                    X           <= active_d ? (h_cnt - h_act_start) : '0;
                    Y           <= active_d ? (v_cnt - v_act_start) : '0;
`endif
                end
                default: begin
                    h_cnt       <= '0;
                    v_cnt       <= '0;
                    H_sync      <= 1'b0;
                    V_sync      <= 1'b0;
                    Active      <= 1'b0;
                    Line_end    <= 1'b0;
                    Frame_start <= 1'b0;
`ifdef PIX_COORD_EN
                    X           <= '0;
                    Y           <= '0;
`endif
                end
            endcase
        end
    end

`ifndef PIX_COORD_EN
    assign X = '0;
    assign Y = '0;
`endif

endmodule
